pipe_out_buffer: RTL and testbench

PIPE_OUT_BUFFER -- requirements
Module: pipe_out_buffer

---
 rtl/pipe_out_buffer.sv | 118 +++++++++++
 tb/tb_pipe_out_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_buffer.sv
// pipe_out_buffer: credit-based output buffer for a fixed-depth, free-running
// M-lane pipeline. Words accepted upstream are tracked through the pipeline by
// a valid shadow register and captured into a first-word-fall-through FIFO as
// they emerge. Credits cover the FIFO plus everything in flight, so the FIFO
// can never overflow.
// Optional occupancy high-water mark: define PIPE_OUT_BUFFER_STATS_EN.
module pipe_out_buffer #(
   parameter int M     = 3,
   parameter int N     = 4,
   parameter int DEPTH = N + 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [M-1:0]                 in_data,
   output logic                         in_ready,
   output logic [M-1:0]                 pipe_in,
   input  logic [M-1:0]                 pipe_out,
   output logic                         out_valid,
   output logic [M-1:0]                 out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   max_level
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N-1:0]  r_vshadow;
   logic [CW-1:0] r_credit;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [M-1:0]  r_mem [DEPTH];

   logic          w_accept;
   logic          w_write;
   logic          w_pop;
   logic [N:0]    w_vs_ext;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_credit_nxt;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
   function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pipe_in   = in_data;
   assign in_ready  = (r_credit != '0);
   assign w_accept  = in_valid & in_ready;
   assign w_write   = r_vshadow[N-1];
   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid & out_ready;
   // Head is forced to zero while empty so reset and idle present out_data = 0
   assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
   assign w_vs_ext  = {r_vshadow, w_accept};

   // Next-state for FIFO occupancy and credit; simultaneous events cancel
   always_comb begin
      w_count_nxt  = r_count;
      w_credit_nxt = r_credit;
      if (w_write && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_write && w_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
      if (w_accept && !w_pop) begin
         w_credit_nxt = r_credit - 1'b1;
      end else if (!w_accept && w_pop) begin
         w_credit_nxt = r_credit + 1'b1;
      end
   end

   // Valid shadow, pointers, occupancy and credit; reset drops in-flight words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vshadow <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_credit  <= CW'(DEPTH);
      end else begin
         r_vshadow <= w_vs_ext[N-1:0];
         r_count   <= w_count_nxt;
         r_credit  <= w_credit_nxt;
         if (w_write) begin
            r_wr_ptr <= f_wrap_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_wrap_inc(r_rd_ptr);
         end
      end
   end

   // FIFO storage captures the pipeline output as the tracked word emerges
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= pipe_out;
      end
   end

`ifdef PIPE_OUT_BUFFER_STATS_EN
   logic [CW-1:0] r_max_level;

   // High-water mark of post-update FIFO occupancy, held until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max_level <= '0;
      end else if (w_count_nxt > r_max_level) begin
         r_max_level <= w_count_nxt;
      end
   end

   assign max_level = r_max_level;
`else
   assign max_level = '0;
`endif

endmodule

// File: tb/tb_pipe_out_buffer.sv
// Directed bench for pipe_out_buffer (M=3, N=4, DEPTH=6) with a behavioural
// N-stage pipeline between pipe_in and pipe_out.
module tb_pipe_out_buffer;

   localparam int M     = 3;
   localparam int N     = 4;
   localparam int DEPTH = 6;
`ifdef PIPE_OUT_BUFFER_STATS_EN
   localparam int ML_FULL = 6;
`else
   localparam int ML_FULL = 0;
`endif

   logic                          clk;
   logic                          rst_n;
   logic                          in_valid;
   logic [M-1:0]                  in_data;
   logic                          in_ready;
   logic [M-1:0]                  pipe_in;
   logic [M-1:0]                  pipe_out;
   logic                          out_valid;
   logic [M-1:0]                  out_data;
   logic                          out_ready;
   logic [$clog2(DEPTH+1)-1:0]    max_level;

   logic [M-1:0] pipe_q [N];

   int checks = 0;
   int errors = 0;

   pipe_out_buffer #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .pipe_in   (pipe_in),
      .pipe_out  (pipe_out),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .max_level (max_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running pipeline with no reset, as the attached one has none
   always_ff @(posedge clk) begin
      pipe_q[0] <= pipe_in;
      for (int k = 1; k < N; k++) pipe_q[k] <= pipe_q[k-1];
   end
   assign pipe_out = pipe_q[N-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset asserted mid-cycle takes effect immediately
      #3 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data",  32'(out_data),  0);
      check("rst_in_ready",  32'(in_ready),  1);
      check("rst_max_level", 32'(max_level), 0);
      tick();
      tick();
      rst_n = 1'b1;
      check("post_rst_in_ready", 32'(in_ready), 1);

      // Single word: accepted on first edge after release, visible after edge 4 only
      in_valid  = 1'b1;
      in_data   = 3'b101;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("lat_out_valid", 32'(out_valid), (i == 4) ? 1 : 0);
         if (i == 4) check("lat_out_data", 32'(out_data), 32'b101);
      end
      tick();
      check("lat_out_valid_after", 32'(out_valid), 0);
      check("lat_in_ready", 32'(in_ready), 1);

      // Backpressure: only DEPTH words accepted while downstream stalls
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         in_data = 3'(i);
         check("bp_in_ready", 32'(in_ready), (i <= 6) ? 1 : 0);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("bp_full_valid", 32'(out_valid), 1);
      check("bp_head",       32'(out_data),  1);
      check("bp_no_credit",  32'(in_ready),  0);
      check("bp_max_level",  32'(max_level), ML_FULL);
      tick();
      check("bp_head_stable", 32'(out_data), 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         check("bp_drain_valid", 32'(out_valid), 1);
         check("bp_drain_data",  32'(out_data),  i);
         tick();
         check("bp_drain_credit", 32'(in_ready), 1);
      end
      check("bp_empty", 32'(out_valid), 0);

      // Write and pop on the same edge with zero credit
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 3'(i + 1);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("wp_no_credit", 32'(in_ready), 0);
      check("wp_head",      32'(out_data), 1);
      out_ready = 1'b1;
      tick();
      check("wp_credit_back", 32'(in_ready),  1);
      check("wp_valid",       32'(out_valid), 1);
      for (int i = 2; i <= 6; i++) begin
         check("wp_drain_data", 32'(out_data), i);
         tick();
      end
      check("wp_empty", 32'(out_valid), 0);

      // Streaming: one word per cycle, never throttled
      for (int i = 0; i < 25; i++) begin
         in_valid = (i < 20);
         in_data  = 3'(i);
         if (i < 20) check("st_in_ready", 32'(in_ready), 1);
         tick();
         if (i >= 4 && i < 24) begin
            check("st_valid", 32'(out_valid), 1);
            check("st_data",  32'(out_data),  (i - 4) & 7);
         end else begin
            check("st_idle", 32'(out_valid), 0);
         end
      end
      in_valid = 1'b0;

      // Mid-flight reset discards words still inside the pipeline
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 3'd7;
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("mf_rst_in_ready",  32'(in_ready),  1);
      check("mf_rst_max_level", 32'(max_level), 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mf_no_valid", 32'(out_valid), 0);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = 3'(i + 1);
         check("mf_credit", 32'(in_ready), (i < 6) ? 1 : 0);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mf_head",      32'(out_data),  1);
      check("mf_max_level", 32'(max_level), ML_FULL);
      out_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         check("mf_drain_data", 32'(out_data), i);
         tick();
      end
      check("mf_empty", 32'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
